// File: rtl/dma_pkg.sv
// Shared definitions for the DMA controller: channel count, channel-index
// width, the priority-resolver state encoding and a one-hot helper.
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } prState_t;

  // One-hot vector with only bit `ch` set.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] one;
    one = NUM_CH'(1);
    return one << ch;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational priority pick: the first requesting channel found when
// scanning upward (mod 4) from topCh wins.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] effReq,
  input  logic [CH_W-1:0]   topCh,
  output logic              any,
  output logic [CH_W-1:0]   winner
);

  // rot_req[k] is the request of the channel k positions below topCh.
  logic [NUM_CH-1:0] rot_req;
  logic [CH_W-1:0]   offset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
      assign rot_req[gi] = effReq[topCh + CH_W'(gi)];
    end
  endgenerate

  // Lowest rotated position with a request wins; scan high-to-low so the
  // last assignment is the lowest set bit.
  always_comb begin
    offset = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_req[i]) offset = CH_W'(i);
    end
  end

  assign any    = |rot_req;
  assign winner = topCh + offset;

endmodule

// File: rtl/dma_priority_resolver.sv
// DREQ conditioning, masking, fixed/rotating arbitration and DACK generation
// for a four-channel 8237A-style DMA controller.
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] requestReg,
  input  logic              cmdDisable,
  input  logic              cmdRotating,
  input  logic              cmdDreqLow,
  input  logic              cmdDackHigh,
  input  logic              hrq,
  input  logic              validDACK,
  input  logic              serviceDone,
  output logic              VALID_DREQ0,
  output logic              VALID_DREQ1,
  output logic              VALID_DREQ2,
  output logic              VALID_DREQ3,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   activeCh
);

  // hrq is informational only; timing control already folds it into
  // validDACK / serviceDone.
  logic unused_hrq;
  assign unused_hrq = hrq;

  // ---------------- request conditioning ----------------
  logic [NUM_CH-1:0] sync_reg  [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_next [SYNC_STAGES];
  logic [NUM_CH-1:0] hw_req;
  logic [NUM_CH-1:0] eff_req;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = DREQ;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Synchronizer shift chain for the asynchronous DREQ pins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= sync_next[i];
    end
  end

  assign hw_req  = sync_reg[SYNC_STAGES-1] ^ {NUM_CH{cmdDreqLow}};
  assign eff_req = cmdDisable ? '0 : ((hw_req | requestReg) & ~maskReg);

  // ---------------- arbitration ----------------
  prState_t          state_reg, state_next;
  logic [CH_W-1:0]   grant_reg, grant_next;
  logic [CH_W-1:0]   top_reg,   top_next;
  logic [NUM_CH-1:0] valid_reg, valid_next;
  logic [NUM_CH-1:0] dack_on_reg, dack_on_next;
  logic              enc_any;
  logic [CH_W-1:0]   enc_winner;

  dma_priority_encoder u_encoder (
    .effReq (eff_req),
    .topCh  (top_reg),
    .any    (enc_any),
    .winner (enc_winner)
  );

  // State and registered outputs; reset wins over any in-flight service.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      top_reg     <= '0;
      valid_reg   <= '0;
      dack_on_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      top_reg     <= top_next;
      valid_reg   <= valid_next;
      dack_on_reg <= dack_on_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (enc_any) state_next = REQ;
      end
      REQ: begin
        if (validDACK)                state_next = SERVICE;
        else if (!eff_req[grant_reg]) state_next = IDLE;
      end
      SERVICE: begin
        // Masking the channel mid-service is ignored: only timing control
        // ends a service.
        if (serviceDone || !validDACK) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant, pointer, VALID_DREQ and DACK register updates.
  always_comb begin
    grant_next   = grant_reg;
    top_next     = cmdRotating ? top_reg : '0;
    valid_next   = valid_reg;
    dack_on_next = dack_on_reg;
    unique case (state_reg)
      IDLE: begin
        if (enc_any) begin
          grant_next = enc_winner;
          valid_next = ch_onehot(enc_winner);
        end
      end
      REQ: begin
        if (validDACK) begin
          dack_on_next = ch_onehot(grant_reg);
        end else if (!eff_req[grant_reg]) begin
          valid_next = '0;
        end
      end
      SERVICE: begin
        if (serviceDone) begin
          valid_next   = '0;
          dack_on_next = '0;
          // Serviced channel drops to lowest priority.
          if (cmdRotating) top_next = grant_reg + CH_W'(1);
        end else if (!validDACK) begin
          valid_next   = '0;
          dack_on_next = '0;
        end
      end
      default: begin
        valid_next   = '0;
        dack_on_next = '0;
      end
    endcase
  end

  assign VALID_DREQ0 = valid_reg[0];
  assign VALID_DREQ1 = valid_reg[1];
  assign VALID_DREQ2 = valid_reg[2];
  assign VALID_DREQ3 = valid_reg[3];
  assign activeCh    = grant_reg;
  // Polarity is applied after the register so a command write takes effect
  // immediately.
  assign DACK        = dack_on_reg ^ {NUM_CH{~cmdDackHigh}};

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver: inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_dma_priority_resolver;
  import dma_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ, maskReg, requestReg;
  logic       cmdDisable, cmdRotating, cmdDreqLow, cmdDackHigh;
  logic       hrq, validDACK, serviceDone;
  logic       VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic [3:0] valid;

  int total = 0;
  int bad   = 0;

  assign valid = {VALID_DREQ3, VALID_DREQ2, VALID_DREQ1, VALID_DREQ0};

  always #5 CLK = ~CLK;

  dma_priority_resolver #(.NUM_CH(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
    .requestReg(requestReg), .cmdDisable(cmdDisable), .cmdRotating(cmdRotating),
    .cmdDreqLow(cmdDreqLow), .cmdDackHigh(cmdDackHigh), .hrq(hrq),
    .validDACK(validDACK), .serviceDone(serviceDone),
    .VALID_DREQ0(VALID_DREQ0), .VALID_DREQ1(VALID_DREQ1),
    .VALID_DREQ2(VALID_DREQ2), .VALID_DREQ3(VALID_DREQ3),
    .DACK(DACK), .activeCh(activeCh)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; DREQ = '0; maskReg = '0; requestReg = '0;
    cmdDisable = 0; cmdRotating = 0; cmdDreqLow = 0; cmdDackHigh = 0;
    hrq = 0; validDACK = 0; serviceDone = 0;
    tick(2);
    RESET = 1'b0;
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", valid); end
    total++; if (DACK !== 4'b1111) begin bad++; $display("FAIL reset_dack got=%b exp=1111", DACK); end
    total++; if (activeCh !== 2'd0) begin bad++; $display("FAIL reset_active got=%0d exp=0", activeCh); end
    total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dut.state_reg); end
    $display("reset: valid=%b dack=%b", valid, DACK);
  endtask

  task automatic test_fixed;
    DREQ = 4'b1010;
    tick(2);
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL fixed_early got=%b exp=0000", valid); end
    tick(1);
    total++; if (valid !== 4'b0010) begin bad++; $display("FAIL fixed_grant got=%b exp=0010", valid); end
    total++; if (activeCh !== 2'd1) begin bad++; $display("FAIL fixed_active got=%0d exp=1", activeCh); end
    validDACK = 1; tick(1);
    total++; if (DACK !== 4'b1101) begin bad++; $display("FAIL fixed_dack got=%b exp=1101", DACK); end
    serviceDone = 1; tick(1);
    serviceDone = 0; validDACK = 0;
    total++; if (valid !== 4'b0000 || DACK !== 4'b1111) begin bad++; $display("FAIL fixed_done got=%b/%b exp=0000/1111", valid, DACK); end
    tick(1);
    total++; if (valid !== 4'b0010) begin bad++; $display("FAIL fixed_regrant got=%b exp=0010", valid); end
    $display("fixed: regrant valid=%b active=%0d", valid, activeCh);
    DREQ = '0; tick(3);
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL fixed_release got=%b exp=0000", valid); end
  endtask

  task automatic test_mask_disable;
    maskReg = 4'b0001; DREQ = 4'b0001;
    tick(4);
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL masked got=%b exp=0000", valid); end
    maskReg = 4'b0000; cmdDisable = 1;
    tick(2);
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL disabled got=%b exp=0000", valid); end
    cmdDisable = 0;
    tick(1);
    total++; if (valid !== 4'b0001) begin bad++; $display("FAIL enable_grant got=%b exp=0001", valid); end
    $display("mask/disable: grant after enable valid=%b", valid);
    DREQ = '0; tick(3);
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL mask_release got=%b exp=0000", valid); end
  endtask

  task automatic test_rotating;
    logic [1:0] exp_seq [5];
    logic [3:0] one;
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    one = 4'b0001;
    cmdRotating = 1; requestReg = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      total++; if (valid !== (one << exp_seq[k]) || activeCh !== exp_seq[k]) begin
        bad++; $display("FAIL rot_grant%0d got=%b/%0d exp_ch=%0d", k, valid, activeCh, exp_seq[k]);
      end
      validDACK = 1; tick(1);
      total++; if (DACK !== ~(one << exp_seq[k])) begin
        bad++; $display("FAIL rot_dack%0d got=%b exp=%b", k, DACK, ~(one << exp_seq[k]));
      end
      serviceDone = 1; tick(1);
      serviceDone = 0; validDACK = 0;
      if (k == 4) requestReg = '0;
      total++; if (valid !== 4'b0000) begin bad++; $display("FAIL rot_clear%0d got=%b exp=0000", k, valid); end
      $display("rotating: service %0d channel=%0d", k, exp_seq[k]);
    end
  endtask

  task automatic test_withdraw;
    // Pointer is 1 after the rotating sequence ended on channel 0.
    DREQ = 4'b0100;
    tick(3);
    total++; if (valid !== 4'b0100) begin bad++; $display("FAIL wd_grant got=%b exp=0100", valid); end
    DREQ = '0;
    tick(2);
    total++; if (valid !== 4'b0100) begin bad++; $display("FAIL wd_hold got=%b exp=0100", valid); end
    tick(1);
    total++; if (valid !== 4'b0000 || dut.state_reg !== IDLE) begin bad++; $display("FAIL wd_drop got=%b state=%0d exp=0000/0", valid, dut.state_reg); end
    total++; if (dut.top_reg !== 2'd1) begin bad++; $display("FAIL wd_top got=%0d exp=1", dut.top_reg); end
    $display("withdraw: valid=%b top=%0d", valid, dut.top_reg);
    cmdRotating = 0; tick(1);
    total++; if (dut.top_reg !== 2'd0) begin bad++; $display("FAIL fixed_top got=%0d exp=0", dut.top_reg); end
  endtask

  task automatic test_polarity;
    cmdRotating = 1; cmdDreqLow = 1; DREQ = 4'b1110;
    tick(3);
    total++; if (valid !== 4'b0001) begin bad++; $display("FAIL pol_grant got=%b exp=0001", valid); end
    validDACK = 1; tick(1);
    total++; if (DACK !== 4'b1110) begin bad++; $display("FAIL pol_dack_low got=%b exp=1110", DACK); end
    cmdDackHigh = 1; #1;
    total++; if (DACK !== 4'b0001) begin bad++; $display("FAIL pol_dack_high got=%b exp=0001", DACK); end
    serviceDone = 1; tick(1);
    serviceDone = 0; validDACK = 0;
    total++; if (DACK !== 4'b0000 || dut.top_reg !== 2'd1) begin bad++; $display("FAIL pol_done got=%b top=%0d exp=0000/1", DACK, dut.top_reg); end
    $display("polarity: dack=%b top=%0d", DACK, dut.top_reg);
  endtask

  task automatic test_reset_mid;
    tick(1);
    total++; if (valid !== 4'b0001) begin bad++; $display("FAIL mid_grant got=%b exp=0001", valid); end
    validDACK = 1; tick(1);
    total++; if (dut.state_reg !== SERVICE || DACK !== 4'b0001) begin bad++; $display("FAIL mid_service got=%0d/%b exp=2/0001", dut.state_reg, DACK); end
    RESET = 1; tick(1);
    total++; if (valid !== 4'b0000 || DACK !== 4'b0000) begin bad++; $display("FAIL mid_reset_out got=%b/%b exp=0000/0000", valid, DACK); end
    total++; if (dut.top_reg !== 2'd0 || activeCh !== 2'd0 || dut.state_reg !== IDLE) begin
      bad++; $display("FAIL mid_reset_state top=%0d act=%0d st=%0d exp=0/0/0", dut.top_reg, activeCh, dut.state_reg);
    end
    $display("reset mid-service: valid=%b dack=%b", valid, DACK);
    RESET = 0; validDACK = 0; cmdDreqLow = 0; DREQ = '0; cmdDackHigh = 0; cmdRotating = 0;
    tick(1);
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_mask_disable;
    test_rotating;
    test_withdraw;
    test_polarity;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_priority_resolver.md
# dma_priority_resolver

Priority resolver for the 8237A-style DMA controller. It sits between the four DREQ request pins and the timing-control block. It conditions and masks the requests, picks one channel under fixed or rotating priority, and presents the winner as one-hot VALID_DREQ0..3 to timing control. It then drives the DACK pins while timing control reports validDACK, and updates the rotating-priority pointer at the end of each service.

## Interface
- NUM_CH, 4: channel count; only 4 is supported.
- SYNC_STAGES, 2: flops in the DREQ synchronizer; legal range 1..3.

- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  4  raw channel request pins, asynchronous.
- maskReg  in  4  mask bits from datapath; 1 = channel masked.
- requestReg  in  4  software request bits; already synchronous, bypass polarity and sync.
- cmdDisable  in  1  command bit 2; 1 = controller disabled, no new grants.
- cmdRotating  in  1  command bit 4; 0 = fixed priority, 1 = rotating.
- cmdDreqLow  in  1  command bit 6; 1 = DREQ active-low.
- cmdDackHigh  in  1  command bit 7; 1 = DACK active-high.
- hrq  in  1  hold request from timing control (observed only; informs state).
- validDACK  in  1  timing control is in service cycles for the granted channel.
- serviceDone  in  1  one-cycle pulse from timing control at end of a service.
- VALID_DREQ0..VALID_DREQ3  out  1 each  registered one-hot grant.
- DACK  out  4  acknowledge pins, polarity per cmdDackHigh.
- activeCh  out  2  encoded granted channel; valid while any VALID_DREQn is high.

## Operation
- Request conditioning:
  - Synchronize each DREQ through SYNC_STAGES flops, then XOR with cmdDreqLow to get hwReq.
  - Effective request: effReq = (hwReq | requestReg) & ~maskReg, forced to 0 when cmdDisable = 1.
- Priority:
  - Fixed mode: channel 0 is highest and 3 is lowest.
  - Rotating mode: a 2-bit pointer topCh names the highest channel; priority descends modulo 4 from topCh.
  - Pointer update: on serviceDone with cmdRotating = 1, topCh becomes grantCh + 1 (mod 4), so the channel just serviced becomes lowest.
  - In fixed mode topCh is forced to 0.
- FSM states:
  - IDLE: when effReq ≠ 0, latch the winner into grantCh, set VALID_DREQ[grantCh], and go to REQ. Otherwise stay.
  - REQ: the grant is frozen, so higher-priority arrivals do not preempt. If validDACK = 1, go to SERVICE. Else if effReq[grantCh] = 0, clear VALID_DREQ and go to IDLE.
  - SERVICE: DACK[grantCh] is active and VALID_DREQ stays set. On serviceDone, apply the rotation update, clear VALID_DREQ, and go to IDLE. If validDACK drops without serviceDone, go to IDLE with no rotation.
- Simultaneous events: serviceDone and a new effReq in the same cycle go to IDLE first; re-arbitration happens the next cycle using the updated topCh.
- Mask changes: setting maskReg[grantCh] while in SERVICE does not abort the service; timing control owns termination.
- DACK = dackOn ^ {4{~cmdDackHigh}}, where dackOn is a registered one-hot, so the polarity change applies combinationally.

## Timing
- Reset values:
  - State = IDLE, grantCh = 0, topCh = 0.
  - VALID_DREQ0..3 = 0, dackOn = 0, activeCh = 0, synchronizer flops = 0.
  - DACK = 4'b1111 when cmdDackHigh = 0.
- RESET asserted in any state returns to these values at the next edge, including mid-service; no rotation update occurs.
- Latency, DREQ pin edge to VALID_DREQ: SYNC_STAGES + 1 cycles (3 by default).
- Latency, requestReg to VALID_DREQ: 1 cycle.
- Latency, validDACK rising to DACK active: 1 cycle.
- Latency, serviceDone to VALID_DREQ/DACK low: 1 cycle.
- Minimum gap between services of different channels: 1 IDLE cycle.

## Structure
- Shared dma_pkg holds:
  - NUM_CH and the CH_W = 2 channel-index width.
  - The prState_t enum {IDLE, REQ, SERVICE}.
- Sub-module dma_priority_encoder: combinational; inputs effReq[3:0] and topCh[1:0]; outputs any and winner[1:0]. It is instantiated once.
- The synchronizer is inline generate logic; no separate module.

## Test plan
- Fixed priority: DREQ = 4'b1010 with mask 0 and cmd 0. Expect VALID_DREQ1 at cycle 3 and activeCh = 1. Then pulse validDACK and serviceDone while DREQ is held; channel 1 is granted again.
- Rotating: cmdRotating = 1 and requestReg = 4'b1111. Expect channel 0 granted first. After serviceDone, grants follow 1, 2, 3, 0 on the following services.
- Masking and disable:
  - DREQ = 4'b0001 with maskReg = 4'b0001: no grant.
  - Same with mask clear and cmdDisable = 1: no grant.
  - Clearing cmdDisable: grant in 1 cycle.
- Request withdrawal: grant channel 2, then drop DREQ2 before validDACK. Expect VALID_DREQ2 low within SYNC_STAGES + 1 cycles, state IDLE, and topCh unchanged.
- Polarity: cmdDreqLow = 1 with DREQ = 4'b1110 yields channel 0. With cmdDackHigh = 0, DACK in service equals 4'b1110; with cmdDackHigh = 1 it equals 4'b0001.
- Reset mid-service: RESET asserted in SERVICE. The next cycle shows all VALID_DREQ low, DACK inactive and topCh = 0.
